// File: rtl/piso_pkg.sv
// piso_pkg: shared definitions for the PISO shift transmitter.
//   piso_state_e   - frame state encoding (IDLE, SHIFT, PARITY)
//   PISO_MAX_WIDTH - largest supported data word
//   clog2()        - bit-counter width for a given word width
package piso_pkg;

  localparam int unsigned PISO_MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } piso_state_e;

  // Bits needed to count 0..n-1; never less than one.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << r) < n) r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/piso_shift_transmitter_bit_counter.sv
// piso_bit_counter: frame bit counter for the PISO transmitter.
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset (count -> 0)
//   en_i  - advance the count by one
//   clr_i - force count to 0 (wins over en_i)
//   tc_o  - terminal count, high while count == WIDTH-1
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int unsigned CntW = clog2(WIDTH);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/piso_shift_transmitter.sv
// piso_shift_transmitter: 74LS165-style parallel-in serial-out framed
// transmitter. A start strobe in IDLE loads d; the word leaves MSB first on
// qh/qh_n, one bit per cycle not held by clk_inh. busy frames the transfer,
// done pulses for one cycle after the last bit.
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   start, d        - frame request and parallel word (sampled in IDLE)
//   ser             - fill bit shifted into the LSB on every shift
//   clk_inh         - freezes the frame in SHIFT/PARITY
//   qh, qh_n        - serial output and its complement
//   busy, done      - frame in progress / end-of-frame pulse
// Build option: define PISO_PARITY_EN to append an even-parity bit (XOR of
// the loaded word) after the data bits.
// DELAY is a simulation-only output delay and has no effect on this RTL's
// cycle behaviour; it is retained for drop-in compatibility.
module piso_shift_transmitter
  import piso_pkg::*;
#(
  parameter int DELAY = 10,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] d,
  input  logic             ser,
  input  logic             clk_inh,
  output logic             qh,
  output logic             qh_n,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2 || WIDTH > int'(PISO_MAX_WIDTH) || DELAY < 0) begin : g_bad_params
    $error("piso_shift_transmitter: WIDTH must be 2..16 and DELAY >= 0");
  end

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cnt_en, cnt_clr, cnt_tc;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk   (clk),
    .rst   (reset),
    .en_i  (cnt_en),
    .clr_i (cnt_clr),
    .tc_o  (cnt_tc)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sr_q     <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_en   = 1'b0;
    cnt_clr  = 1'b0;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_SHIFT;
          sr_d     = d;
          busy_d   = 1'b1;
          cnt_clr  = 1'b1;
`ifdef PISO_PARITY_EN
          parity_d = ^d;
`endif
        end
      end
      ST_SHIFT: begin
        if (!clk_inh) begin
          sr_d = {sr_q[WIDTH-2:0], ser};
          if (cnt_tc) begin
`ifdef PISO_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
`ifdef PISO_PARITY_EN
      ST_PARITY: begin
        if (!clk_inh) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Output logic: every output is a direct function of registered state.
  always_comb begin
    qh = sr_q[WIDTH-1];
`ifdef PISO_PARITY_EN
    if (state_q == ST_PARITY) qh = parity_q;
`endif
    qh_n = ~qh;
    busy = busy_q;
    done = done_q;
  end

endmodule

// File: tb/tb_piso_shift_transmitter.sv
module tb_piso_shift_transmitter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] d;
  logic         ser;
  logic         clk_inh;
  logic         qh, qh_n, busy, done;

  piso_shift_transmitter #(
    .DELAY (10),
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .d       (d),
    .ser     (ser),
    .clk_inh (clk_inh),
    .qh      (qh),
    .qh_n    (qh_n),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           grp;
    logic         st;
    logic [W-1:0] dd;
    logic         s;
    logic         inh;
    logic         eqh;
    logic         ebusy;
    logic         edone;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Expected outputs are those seen just after the clock edge that samples
  // the vector's inputs.
  task automatic add(input int g, input logic st_, input logic [W-1:0] dd_,
                     input logic s_, input logic inh_, input logic eqh_,
                     input logic eb_, input logic ed_);
    vec_t v;
    v.grp = g; v.st = st_; v.dd = dd_; v.s = s_; v.inh = inh_;
    v.eqh = eqh_; v.ebusy = eb_; v.edone = ed_;
    vecs.push_back(v);
  endtask

  // {qh, qh_n, busy, done}
  task automatic check4(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {qh, qh_n, busy, done};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got qh,qh_n,busy,done=%b required %b", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; d = '0; ser = 1'b0; clk_inh = 1'b0;
  endtask

  initial begin
    logic [W-1:0] bits;

    // Group 1: A5, ser=0, plain frame
    add(1, 1, 8'hA5, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 1, 1, 0);
`ifndef PISO_PARITY_EN
    add(1, 0, 8'h00, 0, 0, 0, 0, 1);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0);

    // Group 2: A5, ser=1, clk_inh for 3 cycles while the 4th bit (0) shows;
    // inhibit also asserted in the done cycle, which must not stretch done.
    add(2, 1, 8'hA5, 1, 0, 1, 1, 0);
    add(2, 0, 8'h00, 1, 0, 0, 1, 0);
    add(2, 0, 8'h00, 1, 0, 1, 1, 0);
    add(2, 0, 8'h00, 1, 0, 0, 1, 0);
    add(2, 0, 8'h00, 1, 1, 0, 1, 0);
    add(2, 0, 8'h00, 1, 1, 0, 1, 0);
    add(2, 0, 8'h00, 1, 1, 0, 1, 0);
    add(2, 0, 8'h00, 1, 0, 0, 1, 0);
    add(2, 0, 8'h00, 1, 0, 1, 1, 0);
    add(2, 0, 8'h00, 1, 0, 0, 1, 0);
    add(2, 0, 8'h00, 1, 0, 1, 1, 0);
    add(2, 0, 8'h00, 1, 0, 1, 0, 1);
    add(2, 0, 8'h00, 1, 1, 1, 0, 0);
    add(2, 0, 8'h00, 1, 0, 1, 0, 0);

    // Group 3: start with FF on the 4th frame cycle is ignored.
    add(3, 1, 8'hA5, 0, 0, 1, 1, 0);
    add(3, 0, 8'h00, 0, 0, 0, 1, 0);
    add(3, 0, 8'h00, 0, 0, 1, 1, 0);
    add(3, 1, 8'hFF, 0, 0, 0, 1, 0);
    add(3, 0, 8'h00, 0, 0, 0, 1, 0);
    add(3, 0, 8'h00, 0, 0, 1, 1, 0);
    add(3, 0, 8'h00, 0, 0, 0, 1, 0);
    add(3, 0, 8'h00, 0, 0, 1, 1, 0);
    add(3, 0, 8'h00, 0, 0, 0, 0, 1);
    add(3, 0, 8'h00, 0, 0, 0, 0, 0);

    // Group 4: A5 then 3C started in the done cycle (back-to-back).
    add(4, 1, 8'hA5, 0, 0, 1, 1, 0);
    add(4, 0, 8'h00, 0, 0, 0, 1, 0);
    add(4, 0, 8'h00, 0, 0, 1, 1, 0);
    add(4, 0, 8'h00, 0, 0, 0, 1, 0);
    add(4, 0, 8'h00, 0, 0, 0, 1, 0);
    add(4, 0, 8'h00, 0, 0, 1, 1, 0);
    add(4, 0, 8'h00, 0, 0, 0, 1, 0);
    add(4, 0, 8'h00, 0, 0, 1, 1, 0);
    add(4, 0, 8'h00, 0, 0, 0, 0, 1);
    add(4, 1, 8'h3C, 0, 0, 0, 1, 0);
    add(4, 0, 8'h00, 0, 0, 0, 1, 0);
    add(4, 0, 8'h00, 0, 0, 1, 1, 0);
    add(4, 0, 8'h00, 0, 0, 1, 1, 0);
    add(4, 0, 8'h00, 0, 0, 1, 1, 0);
    add(4, 0, 8'h00, 0, 0, 1, 1, 0);
    add(4, 0, 8'h00, 0, 0, 0, 1, 0);
    add(4, 0, 8'h00, 0, 0, 0, 1, 0);
    add(4, 0, 8'h00, 0, 0, 0, 0, 1);
    add(4, 0, 8'h00, 0, 0, 0, 0, 0);
`else
    // Parity bit of A5 is 0, then done on the 10th cycle.
    add(1, 0, 8'h00, 0, 0, 0, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 0, 1);
    add(1, 0, 8'h00, 0, 0, 0, 0, 0);

    // Group 5: 07 -> 0,0,0,0,0,1,1,1 then parity 1; ser=0.
    add(5, 1, 8'h07, 0, 0, 0, 1, 0);
    add(5, 0, 8'h00, 0, 0, 0, 1, 0);
    add(5, 0, 8'h00, 0, 0, 0, 1, 0);
    add(5, 0, 8'h00, 0, 0, 0, 1, 0);
    add(5, 0, 8'h00, 0, 0, 0, 1, 0);
    add(5, 0, 8'h00, 0, 0, 1, 1, 0);
    add(5, 0, 8'h00, 0, 0, 1, 1, 0);
    add(5, 0, 8'h00, 0, 0, 1, 1, 0);
    add(5, 0, 8'h00, 0, 0, 1, 1, 0);
    add(5, 0, 8'h00, 0, 1, 1, 1, 0);
    add(5, 0, 8'h00, 0, 0, 0, 0, 1);
    add(5, 0, 8'h00, 0, 0, 0, 0, 0);

    // Group 6: 03 with ser=1 -> parity bit 0 even though the fill is ones.
    add(6, 1, 8'h03, 1, 0, 0, 1, 0);
    add(6, 0, 8'h00, 1, 0, 0, 1, 0);
    add(6, 0, 8'h00, 1, 0, 0, 1, 0);
    add(6, 0, 8'h00, 1, 0, 0, 1, 0);
    add(6, 0, 8'h00, 1, 0, 0, 1, 0);
    add(6, 0, 8'h00, 1, 0, 0, 1, 0);
    add(6, 0, 8'h00, 1, 0, 1, 1, 0);
    add(6, 0, 8'h00, 1, 0, 1, 1, 0);
    add(6, 0, 8'h00, 1, 0, 0, 1, 0);
    add(6, 0, 8'h00, 1, 0, 1, 0, 1);
    add(6, 0, 8'h00, 1, 0, 1, 0, 0);
`endif

    // Power-on reset
    idle_inputs();
    reset = 1'b1;
    #1;
    check4("reset_initial", 4'b1000);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check4("idle_after_reset", 4'b1000);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      start   = vecs[i].st;
      d       = vecs[i].dd;
      ser     = vecs[i].s;
      clk_inh = vecs[i].inh;
      @(posedge clk); #1;
      n_vec++;
      if ({qh, qh_n, busy, done} !== {vecs[i].eqh, ~vecs[i].eqh, vecs[i].ebusy, vecs[i].edone}) begin
        n_err++;
        $display("FAIL vec%0d grp%0d: got qh=%b qh_n=%b busy=%b done=%b required qh=%b qh_n=%b busy=%b done=%b",
                 i, vecs[i].grp, qh, qh_n, busy, done,
                 vecs[i].eqh, ~vecs[i].eqh, vecs[i].ebusy, vecs[i].edone);
      end
    end
    idle_inputs();

    // Asynchronous reset mid-frame: takes effect between edges.
    start = 1'b1; d = 8'h5A;
    @(posedge clk); #1;
    start = 1'b0; d = '0;
    @(posedge clk); #1;
    check4("midframe_bit1", 4'b1010);
    #3;
    reset = 1'b1;
    #1;
    check4("async_reset_midframe", 4'b1000);
    @(posedge clk); #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check4("post_reset_idle", 4'b1000);
    end

    // Reset on the last data bit: the aborted frame never raises done.
    start = 1'b1; d = 8'h01;
    @(posedge clk); #1;
    start = 1'b0; d = '0;
    for (int k = 0; k < W - 1; k++) @(posedge clk);
    #1;
    check4("last_bit_shown", 4'b1010);
    reset = 1'b1;
    #1;
    check4("async_reset_lastbit", 4'b1000);
    #2;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check4("no_done_after_abort", 4'b1000);
    end

    // Walking-one words: qh must follow each bit MSB first.
    for (int w = 0; w < 3; w++) begin
      bits = 8'h80 >> (w * 3);
      start = 1'b1; d = bits; ser = 1'b0;
      for (int k = 0; k < W; k++) begin
        @(posedge clk); #1;
        start = 1'b0; d = '0;
        check4("walk_bit", {bits[W-1-k], ~bits[W-1-k], 1'b1, 1'b0});
      end
`ifdef PISO_PARITY_EN
      @(posedge clk); #1;
      check4("walk_parity", 4'b1010);
`endif
      @(posedge clk); #1;
      check4("walk_done", 4'b0101);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
